// File: rtl/sprite_scan_overlay_if.sv
// Scan-side bundle for the sprite overlay: timing/position inputs, mask ROM
// address/data and composited pixel output.
interface sprite_scan_overlay_if;
    logic [10:0] hcnt;
    logic [10:0] vcnt;
    logic        frame_start;
    logic [10:0] pos_x;
    logic [10:0] pos_y;
    logic        en;
    logic [11:0] bg_rgb;
    logic        blink_req;
    logic [3:0]  blink_count;
    logic [10:0] ix;
    logic [10:0] iy;
    logic        mask;
    logic [11:0] rgb_out;
    logic        busy;

    modport master (
        output hcnt, vcnt, frame_start, pos_x, pos_y, en, bg_rgb,
               blink_req, blink_count, mask,
        input  ix, iy, rgb_out, busy
    );

    modport slave (
        input  hcnt, vcnt, frame_start, pos_x, pos_y, en, bg_rgb,
               blink_req, blink_count, mask,
        output ix, iy, rgb_out, busy
    );
endinterface

// File: rtl/sprite_scan_overlay.sv
// Sprite overlay: maps scan position to sprite-local mask ROM address, aligns the
// returned mask with the background stream and composites; frame-counted blink FSM.
module sprite_scan_overlay #(
    parameter int          SPR_W        = 64,
    parameter int          SPR_H        = 64,
    parameter int          MASK_LAT     = 1,
    parameter logic [11:0] SPR_COLOR    = 12'hF80,
    parameter int          BLINK_FRAMES = 16
) (
    input logic                 clk,
    input logic                 rst,
    sprite_scan_overlay_if.slave bus
);
    localparam int D  = 1 + MASK_LAT;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_OFF, ST_ON} state_t;

    state_t               state_q, state_d;
    logic [10:0]          org_x_q, org_x_d;
    logic [10:0]          org_y_q, org_y_d;
    logic                 en_q, en_d;
    logic [10:0]          ix_q, ix_d;
    logic [10:0]          iy_q, iy_d;
    logic [D-1:0]         box_pipe_q, box_pipe_d;
    logic [D-1:0][11:0]   bg_pipe_q, bg_pipe_d;
    logic [11:0]          rgb_q, rgb_d;
    logic                 vis_q, vis_d;
    logic [3:0]           rem_q, rem_d;
    logic [FW-1:0]        frm_cnt_q, frm_cnt_d;
    logic                 in_box;
    logic                 last_frame;

    // Compare in 12 bits so a sprite near x/y=2047 never wraps onto column/row 0.
    always_comb begin
        in_box = en_q
              && ({1'b0, bus.hcnt} >= {1'b0, org_x_q})
              && ({1'b0, bus.hcnt} <  {1'b0, org_x_q} + 12'(SPR_W))
              && ({1'b0, bus.vcnt} >= {1'b0, org_y_q})
              && ({1'b0, bus.vcnt} <  {1'b0, org_y_q} + 12'(SPR_H));
    end

    always_comb begin
        org_x_d = org_x_q;
        org_y_d = org_y_q;
        en_d    = en_q;
        if (bus.frame_start) begin
            org_x_d = bus.pos_x;
            org_y_d = bus.pos_y;
            en_d    = bus.en;
        end

        ix_d = in_box ? (bus.hcnt - org_x_q) : 11'h7FF;
        iy_d = in_box ? (bus.vcnt - org_y_q) : 11'h7FF;

        box_pipe_d   = {box_pipe_q[D-2:0], in_box};
        bg_pipe_d    = bg_pipe_q;
        bg_pipe_d[0] = bus.bg_rgb;
        for (int i = 1; i < D; i++) begin
            bg_pipe_d[i] = bg_pipe_q[i-1];
        end

        rgb_d = (box_pipe_q[D-1] && bus.mask && vis_q) ? SPR_COLOR : bg_pipe_q[D-1];
    end

    assign last_frame = (frm_cnt_q == FW'(BLINK_FRAMES - 1));

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        frm_cnt_d = frm_cnt_q;
        vis_d     = vis_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.blink_req && (bus.blink_count != 4'd0)) begin
                    state_d   = ST_OFF;
                    rem_d     = bus.blink_count;
                    frm_cnt_d = '0;
                end
            end
            ST_OFF: begin
                if (bus.frame_start) begin
                    if (last_frame) begin
                        state_d   = ST_ON;
                        frm_cnt_d = '0;
                    end else begin
                        frm_cnt_d = frm_cnt_q + FW'(1);
                    end
                end
            end
            ST_ON: begin
                if (bus.frame_start) begin
                    if (last_frame) begin
                        rem_d     = rem_q - 4'd1;
                        frm_cnt_d = '0;
                        state_d   = (rem_q == 4'd1) ? ST_IDLE : ST_OFF;
                    end else begin
                        frm_cnt_d = frm_cnt_q + FW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Visibility follows the state chosen at this frame boundary, never mid-frame.
        if (bus.frame_start) begin
            vis_d = (state_d != ST_OFF);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            org_x_q    <= '0;
            org_y_q    <= '0;
            en_q       <= 1'b0;
            ix_q       <= 11'h7FF;
            iy_q       <= 11'h7FF;
            box_pipe_q <= '0;
            bg_pipe_q  <= '0;
            rgb_q      <= '0;
            vis_q      <= 1'b1;
            rem_q      <= '0;
            frm_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            org_x_q    <= org_x_d;
            org_y_q    <= org_y_d;
            en_q       <= en_d;
            ix_q       <= ix_d;
            iy_q       <= iy_d;
            box_pipe_q <= box_pipe_d;
            bg_pipe_q  <= bg_pipe_d;
            rgb_q      <= rgb_d;
            vis_q      <= vis_d;
            rem_q      <= rem_d;
            frm_cnt_q  <= frm_cnt_d;
        end
    end

    assign bus.ix      = ix_q;
    assign bus.iy      = iy_q;
    assign bus.rgb_out = rgb_q;
    assign bus.busy    = (state_q != ST_IDLE);
endmodule

// File: tb/tb_sprite_scan_overlay.sv
// Directed bench for sprite_scan_overlay: scan lines against a tiny ROM model,
// shadow-register latching, no-wrap edge, blink schedule and async reset.
module tb_sprite_scan_overlay;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sprite_scan_overlay_if bus();

    sprite_scan_overlay #(.BLINK_FRAMES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int rom_mode = 1;   // 0: all clear, 1: all set, 2: ix[0]

    // Mask ROM model with one cycle of read latency.
    always @(posedge clk) begin
        bus.mask <= (rom_mode == 0) ? 1'b0 : (rom_mode == 1) ? 1'b1 : bus.ix[0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] bgf(input logic [10:0] h);
        return {1'b0, h} + 12'h123;
    endfunction

    function automatic logic inb(input logic [10:0] h, input logic [10:0] v,
                                 input logic [10:0] ox, input logic [10:0] oy, input logic e);
        return e && (h >= ox) && (int'(h) < int'(ox) + 64)
                 && (v >= oy) && (int'(v) < int'(oy) + 64);
    endfunction

    task automatic pulse_fs(input logic req, input logic [3:0] cnt);
        bus.frame_start = 1'b1;
        bus.blink_req   = req;
        bus.blink_count = cnt;
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
        bus.blink_req   = 1'b0;
    endtask

    // Streams n pixels of row v from h0; ix/iy checked one edge later, rgb_out three.
    task automatic scan_line(input logic [10:0] v, input logic [10:0] h0, input int n,
                             input logic [10:0] ox, input logic [10:0] oy,
                             input logic e, input logic vis);
        logic [10:0] h, p, lx;
        logic        m;
        logic [11:0] exp_rgb;
        $display("scan row=%0d h0=%0d n=%0d org=(%0d,%0d) en=%0b vis=%0b rom=%0d",
                 v, h0, n, ox, oy, e, vis, rom_mode);
        for (int c = 0; c < n + 2; c++) begin
            if (c < n) begin
                h = h0 + 11'(c);
                bus.hcnt   = h;
                bus.vcnt   = v;
                bus.bg_rgb = bgf(h);
            end
            @(posedge clk); #1;
            if (c < n) begin
                h = h0 + 11'(c);
                check($sformatf("ix@%0d,%0d", h, v), 32'(bus.ix),
                      32'(inb(h, v, ox, oy, e) ? h - ox : 11'h7FF));
                check($sformatf("iy@%0d,%0d", h, v), 32'(bus.iy),
                      32'(inb(h, v, ox, oy, e) ? v - oy : 11'h7FF));
            end
            if (c >= 2) begin
                p  = h0 + 11'(c - 2);
                lx = p - ox;
                m  = (rom_mode == 0) ? 1'b0 : (rom_mode == 1) ? 1'b1 : lx[0];
                exp_rgb = (inb(p, v, ox, oy, e) && m && vis) ? 12'hF80 : bgf(p);
                check($sformatf("rgb@%0d,%0d", p, v), 32'(bus.rgb_out), 32'(exp_rgb));
            end
        end
    endtask

    initial begin
        bus.hcnt = '0; bus.vcnt = '0; bus.frame_start = 1'b0;
        bus.pos_x = '0; bus.pos_y = '0; bus.en = 1'b0; bus.bg_rgb = '0;
        bus.blink_req = 1'b0; bus.blink_count = '0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check("rst_rgb", 32'(bus.rgb_out), 32'h0);
        check("rst_ix", 32'(bus.ix), 32'h7FF);
        check("rst_iy", 32'(bus.iy), 32'h7FF);
        check("rst_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;

        // Basic overlay at (100,50), including right/bottom edges
        bus.pos_x = 11'd100; bus.pos_y = 11'd50; bus.en = 1'b1;
        pulse_fs(1'b0, 4'd0);
        scan_line(11'd50, 11'd96, 72, 11'd100, 11'd50, 1'b1, 1'b1);
        scan_line(11'd113, 11'd98, 4, 11'd100, 11'd50, 1'b1, 1'b1);
        scan_line(11'd114, 11'd98, 4, 11'd100, 11'd50, 1'b1, 1'b1);
        scan_line(11'd49, 11'd98, 4, 11'd100, 11'd50, 1'b1, 1'b1);

        // Position change without frame_start has no effect until the next frame
        bus.pos_x = 11'd200;
        scan_line(11'd50, 11'd90, 180, 11'd100, 11'd50, 1'b1, 1'b1);
        pulse_fs(1'b0, 4'd0);
        scan_line(11'd50, 11'd190, 80, 11'd200, 11'd50, 1'b1, 1'b1);

        // Sprite at the right edge never wraps to column 0
        bus.pos_x = 11'd2000;
        pulse_fs(1'b0, 4'd0);
        scan_line(11'd50, 11'd1990, 128, 11'd2000, 11'd50, 1'b1, 1'b1);

        // Mask clear inside the box, then a patterned mask with set bits outside
        bus.pos_x = 11'd100;
        pulse_fs(1'b0, 4'd0);
        rom_mode = 0;
        scan_line(11'd60, 11'd96, 72, 11'd100, 11'd50, 1'b1, 1'b1);
        rom_mode = 2;
        scan_line(11'd60, 11'd96, 72, 11'd100, 11'd50, 1'b1, 1'b1);
        rom_mode = 1;

        // Blink: 2 OFF/ON pairs of 4 frames, request coincident with frame 0
        for (int k = 0; k <= 16; k++) begin
            pulse_fs((k == 0) || (k == 5), 4'd2);
            check($sformatf("busy_f%0d", k), 32'(bus.busy), 32'((k < 16) ? 1 : 0));
            scan_line(11'd50, 11'd99, 3, 11'd100, 11'd50, 1'b1,
                      !((k < 4) || (k >= 8 && k < 12)));
        end

        // Asynchronous reset in the middle of a visible blink phase
        pulse_fs(1'b1, 4'd1);
        for (int k = 0; k < 4; k++) pulse_fs(1'b0, 4'd1);
        scan_line(11'd50, 11'd100, 1, 11'd100, 11'd50, 1'b1, 1'b1);
        check("pre_rst_busy", 32'(bus.busy), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("arst_rgb", 32'(bus.rgb_out), 32'h0);
        check("arst_ix", 32'(bus.ix), 32'h7FF);
        check("arst_iy", 32'(bus.iy), 32'h7FF);
        check("arst_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        scan_line(11'd50, 11'd96, 8, 11'd0, 11'd0, 1'b0, 1'b1);
        scan_line(11'd0, 11'd0, 4, 11'd0, 11'd0, 1'b0, 1'b1);
        pulse_fs(1'b0, 4'd0);
        scan_line(11'd50, 11'd96, 8, 11'd100, 11'd50, 1'b1, 1'b1);

        // en=0 latched: nothing addressed anywhere in the frame
        bus.en = 1'b0;
        pulse_fs(1'b0, 4'd0);
        scan_line(11'd50, 11'd90, 90, 11'd100, 11'd50, 1'b0, 1'b1);
        scan_line(11'd113, 11'd90, 90, 11'd100, 11'd50, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
